// File: rtl/parallel_serial.sv
//==============================================================================
// parallel_serial : QPSK I/Q pair re-serialiser with one-pair skid buffer and
// sticky overflow. Optional Barker-13 detect via `define BARKER_SYNC_EN. Rev 1.0
//==============================================================================
`default_nettype none

module parallel_serial #(
  parameter int BIT_DIV = 2
) (
  input  logic       clk_fs,
  input  logic       rst_n,
  input  logic [1:0] data_in_I,
  input  logic [1:0] data_in_Q,
  input  logic       sym_valid,
  output logic       data_out,
  output logic       data_valid,
  output logic       overflow,
  output logic       sym_err,
  output logic       frame_sync
);

  localparam logic [3:0] LAST_CNT = 4'(BIT_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       sh_i, sh_q, sh_i_nx, sh_q_nx;
  logic       pend_full, pend_i, pend_q;
  logic       pend_full_nx, pend_i_nx, pend_q_nx;
  logic       out_nx, valid_nx, ovf_nx, err_nx;
  logic       last, code_ok, q_handoff;

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sh_i       <= 1'b0;
      sh_q       <= 1'b0;
      pend_full  <= 1'b0;
      pend_i     <= 1'b0;
      pend_q     <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      sym_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sh_i       <= sh_i_nx;
      sh_q       <= sh_q_nx;
      pend_full  <= pend_full_nx;
      pend_i     <= pend_i_nx;
      pend_q     <= pend_q_nx;
      data_out   <= out_nx;
      data_valid <= valid_nx;
      overflow   <= ovf_nx;
      sym_err    <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sh_i_nx      = sh_i;
    sh_q_nx      = sh_q;
    pend_full_nx = pend_full;
    pend_i_nx    = pend_i;
    pend_q_nx    = pend_q;
    out_nx       = data_out;
    valid_nx     = 1'b0;
    ovf_nx       = overflow;
    err_nx       = 1'b0;
    last         = (cnt == LAST_CNT);
    code_ok      = data_in_I[0] & data_in_Q[0];
    q_handoff    = (state == SEND_Q) && last;

    case (state)
      IDLE: begin
        out_nx = 1'b0;
        if (sym_valid) begin
          sh_i_nx  = data_in_I[1];
          sh_q_nx  = data_in_Q[1];
          out_nx   = data_in_I[1];
          valid_nx = 1'b1;
          err_nx   = ~code_ok;
          cnt_nx   = 4'd0;
          state_nx = SEND_I;
        end
      end
      SEND_I: begin
        if (last) begin
          out_nx   = sh_q;
          valid_nx = 1'b1;
          cnt_nx   = 4'd0;
          state_nx = SEND_Q;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      SEND_Q: begin
        if (last) begin
          cnt_nx = 4'd0;
          if (pend_full) begin
            sh_i_nx      = pend_i;
            sh_q_nx      = pend_q;
            out_nx       = pend_i;
            valid_nx     = 1'b1;
            state_nx     = SEND_I;
            pend_full_nx = sym_valid;
            if (sym_valid) begin
              pend_i_nx = data_in_I[1];
              pend_q_nx = data_in_Q[1];
              err_nx    = ~code_ok;
            end
          end else if (sym_valid) begin
            sh_i_nx  = data_in_I[1];
            sh_q_nx  = data_in_Q[1];
            out_nx   = data_in_I[1];
            valid_nx = 1'b1;
            err_nx   = ~code_ok;
            state_nx = SEND_I;
          end else begin
            out_nx   = 1'b0;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        out_nx   = 1'b0;
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
    endcase

    // Strobes arriving mid-burst go to the skid slot or are dropped.
    if (sym_valid && (state != IDLE) && !q_handoff) begin
      if (!pend_full) begin
        pend_full_nx = 1'b1;
        pend_i_nx    = data_in_I[1];
        pend_q_nx    = data_in_Q[1];
        err_nx       = ~code_ok;
      end else begin
        ovf_nx = 1'b1;
      end
    end
  end

`ifdef BARKER_SYNC_EN
  localparam logic [12:0] BARKER = 13'b1111100110101;
  logic [12:0] barker_sr;
  logic [12:0] barker_nx;

  assign barker_nx = {barker_sr[11:0], out_nx};

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      barker_sr  <= 13'd0;
      frame_sync <= 1'b0;
    end else begin
      if (valid_nx) begin
        barker_sr <= barker_nx;
      end
      frame_sync <= valid_nx && (barker_nx == BARKER);
    end
  end
`else
  assign frame_sync = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parallel_serial.sv
//==============================================================================
// tb_parallel_serial : randomized bench for parallel_serial against a
// pair-occupancy reference model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_parallel_serial;

  localparam int BD   = 2;
  localparam int MAXC = 400;
  localparam logic [12:0] BARKER = 13'b1111100110101;

  logic       clk_fs = 1'b0;
  logic       rst_n;
  logic [1:0] data_in_I, data_in_Q;
  logic       sym_valid;
  logic       data_out, data_valid, overflow, sym_err, frame_sync;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    int         t;
    logic [1:0] i;
    logic [1:0] q;
  } strobe_t;

  strobe_t sched[$];
  logic exp_out[MAXC], exp_val[MAXC], exp_ovf[MAXC], exp_err[MAXC], exp_fs[MAXC];
  logic obs_out[MAXC], obs_val[MAXC], obs_ovf[MAXC], obs_err[MAXC], obs_fs[MAXC];

  parallel_serial #(.BIT_DIV(BD)) dut (
    .clk_fs     (clk_fs),
    .rst_n      (rst_n),
    .data_in_I  (data_in_I),
    .data_in_Q  (data_in_Q),
    .sym_valid  (sym_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overflow   (overflow),
    .sym_err    (sym_err),
    .frame_sync (frame_sync)
  );

  always #5 clk_fs = ~clk_fs;

  task automatic tick();
    @(posedge clk_fs);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    data_in_I = 2'b01;
    data_in_Q = 2'b01;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Each accepted pair occupies output cycles [s, s+2*BD-1]; at most two pairs
  // (one in flight, one waiting) may be outstanding beyond a strobe's cycle.
  task automatic build_model(input int ncyc);
    int          s_q[$];
    int          e_q[$];
    logic        bi_q[$];
    logic        bq_q[$];
    int          drop_t;
    int          busy;
    int          s;
    logic [12:0] hist;
    drop_t = -1;
    hist   = 13'd0;
    for (int c = 0; c < MAXC; c++) begin
      exp_out[c] = 0; exp_val[c] = 0; exp_ovf[c] = 0; exp_err[c] = 0; exp_fs[c] = 0;
    end
    foreach (sched[k]) begin
      busy = 0;
      foreach (e_q[j]) if (e_q[j] > sched[k].t) busy++;
      if (busy < 2) begin
        s = sched[k].t + 1;
        if (e_q.size() > 0 && e_q[e_q.size()-1] + 1 > s) s = e_q[e_q.size()-1] + 1;
        s_q.push_back(s);
        e_q.push_back(s + 2*BD - 1);
        bi_q.push_back(sched[k].i[1]);
        bq_q.push_back(sched[k].q[1]);
        if (!(sched[k].i[0] && sched[k].q[0])) exp_err[sched[k].t + 1] = 1;
      end else if (drop_t < 0) begin
        drop_t = sched[k].t;
      end
    end
    for (int c = 1; c <= ncyc; c++) begin
      exp_ovf[c] = (drop_t >= 0) && (c > drop_t);
      foreach (s_q[j]) begin
        if (c >= s_q[j] && c <= e_q[j]) begin
          exp_out[c] = (c < s_q[j] + BD) ? bi_q[j] : bq_q[j];
          exp_val[c] = (c == s_q[j]) || (c == s_q[j] + BD);
        end
      end
`ifdef BARKER_SYNC_EN
      if (exp_val[c]) begin
        hist      = {hist[11:0], exp_out[c]};
        exp_fs[c] = (hist == BARKER);
      end
`endif
    end
  endtask

  task automatic run_sched(input int ncyc);
    build_model(ncyc);
    for (int t = 0; t < ncyc; t++) begin
      sym_valid = 1'b0;
      data_in_I = 2'($urandom);
      data_in_Q = 2'($urandom);
      foreach (sched[k]) begin
        if (sched[k].t == t) begin
          sym_valid = 1'b1;
          data_in_I = sched[k].i;
          data_in_Q = sched[k].q;
        end
      end
      tick();
      obs_out[t+1] = data_out;
      obs_val[t+1] = data_valid;
      obs_ovf[t+1] = overflow;
      obs_err[t+1] = sym_err;
      obs_fs[t+1]  = frame_sync;
    end
    sym_valid = 1'b0;
  endtask

  function automatic logic [1:0] code(input logic b);
    return b ? 2'b11 : 2'b01;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    data_in_I = 2'b11;
    data_in_Q = 2'b11;
    tick();
    n_total++;
    if ({data_out, data_valid, overflow, sym_err, frame_sync} !== 5'b0)
      $display("FAIL reset_state got %b exp 00000",
               {data_out, data_valid, overflow, sym_err, frame_sync});
    else n_pass++;
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if ({data_out, data_valid, overflow, sym_err, frame_sync} !== 5'b0)
      $display("FAIL idle_after_reset got %b exp 00000",
               {data_out, data_valid, overflow, sym_err, frame_sync});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [5:1] e_o;
    logic [5:1] e_v;
    e_o = 5'b00011;
    e_v = 5'b00101;
    do_reset();
    sched.delete();
    sched.push_back('{t: 0, i: 2'b11, q: 2'b01});
    run_sched(6);
    for (int c = 1; c <= 5; c++) begin
      n_total++;
      if ({obs_out[c], obs_val[c]} !== {e_o[c], e_v[c]})
        $display("FAIL single cycle %0d out/val got %b%b exp %b%b",
                 c, obs_out[c], obs_val[c], e_o[c], e_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int nval;
    do_reset();
    sched.delete();
    for (int k = 0; k < 20; k++)
      sched.push_back('{t: 4*k, i: code(1'($urandom)), q: code(1'($urandom))});
    run_sched(90);
    nval = 0;
    for (int c = 1; c <= 90; c++) begin
      nval += int'(obs_val[c]);
      n_total++;
      if ({obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]} !==
          {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]})
        $display("FAIL b2b cycle %0d got %b exp %b", c,
                 {obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]},
                 {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]});
      else n_pass++;
    end
    for (int c = 1; c <= 80; c++) begin
      n_total++;
      if (obs_val[c] !== ((c % 2) == 1))
        $display("FAIL b2b_gapless cycle %0d valid got %b exp %b", c, obs_val[c], (c % 2) == 1);
      else n_pass++;
    end
    n_total++;
    if (nval != 40) $display("FAIL b2b_bitcount got %0d exp 40", nval);
    else n_pass++;
    n_total++;
    if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b exp 0", overflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    sched.delete();
    for (int k = 0; k < 3; k++)
      sched.push_back('{t: k, i: code(1'($urandom)), q: code(1'($urandom))});
    run_sched(14);
    for (int c = 1; c <= 14; c++) begin
      n_total++;
      if ({obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]} !==
          {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]})
        $display("FAIL overflow cycle %0d got %b exp %b", c,
                 {obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]},
                 {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]});
      else n_pass++;
    end
    n_total++;
    if ({obs_ovf[2], obs_ovf[3], obs_ovf[14]} !== 3'b011)
      $display("FAIL overflow_timing got %b exp 011", {obs_ovf[2], obs_ovf[3], obs_ovf[14]});
    else n_pass++;
  endtask

  task automatic test_sym_err();
    int nerr;
    do_reset();
    sched.delete();
    sched.push_back('{t: 0, i: 2'b10, q: 2'b01});
    sched.push_back('{t: 1, i: 2'b01, q: 2'b11});
    sched.push_back('{t: 2, i: 2'b00, q: 2'b00});
    run_sched(14);
    nerr = 0;
    for (int c = 1; c <= 14; c++) nerr += int'(obs_err[c]);
    n_total++;
    if ({obs_err[1], obs_out[1], obs_val[1]} !== 3'b111)
      $display("FAIL sym_err_first got err/out/val %b exp 111", {obs_err[1], obs_out[1], obs_val[1]});
    else n_pass++;
    n_total++;
    if (nerr != 1) $display("FAIL sym_err_count got %0d exp 1", nerr);
    else n_pass++;
    for (int c = 1; c <= 14; c++) begin
      n_total++;
      if ({obs_out[c], obs_val[c], obs_ovf[c], obs_err[c]} !==
          {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c]})
        $display("FAIL sym_err cycle %0d got %b exp %b", c,
                 {obs_out[c], obs_val[c], obs_ovf[c], obs_err[c]},
                 {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c]});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    sym_valid = 1'b1;
    data_in_I = 2'b11; data_in_Q = 2'b11; tick();
    data_in_I = 2'b01; data_in_Q = 2'b11; tick();
    data_in_I = 2'b11; data_in_Q = 2'b11; tick();
    sym_valid = 1'b0;
    n_total++;
    if ({data_out, overflow} !== 2'b11)
      $display("FAIL pre_reset out/ovf got %b exp 11", {data_out, overflow});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({data_out, data_valid, overflow, sym_err, frame_sync} !== 5'b0)
      $display("FAIL async_reset got %b exp 00000",
               {data_out, data_valid, overflow, sym_err, frame_sync});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if ({data_out, data_valid, overflow, sym_err, frame_sync} !== 5'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL residual_after_reset got %0d busy cycles exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_barker();
    logic [13:0] bits;
    int          nfs;
    int          fs_cyc;
    int          exp_nfs;
    int          exp_cyc;
    bits = 14'b11111001101010;
`ifdef BARKER_SYNC_EN
    exp_nfs = 1; exp_cyc = 25;
`else
    exp_nfs = 0; exp_cyc = -1;
`endif
    do_reset();
    sched.delete();
    for (int k = 0; k < 7; k++)
      sched.push_back('{t: 4*k, i: code(bits[13-2*k]), q: code(bits[12-2*k])});
    run_sched(34);
    nfs = 0;
    fs_cyc = -1;
    for (int c = 1; c <= 34; c++) begin
      if (obs_fs[c]) begin nfs++; fs_cyc = c; end
      n_total++;
      if ({obs_out[c], obs_val[c], obs_fs[c]} !== {exp_out[c], exp_val[c], exp_fs[c]})
        $display("FAIL barker cycle %0d out/val/fs got %b exp %b", c,
                 {obs_out[c], obs_val[c], obs_fs[c]}, {exp_out[c], exp_val[c], exp_fs[c]});
      else n_pass++;
    end
    n_total++;
    if (nfs != exp_nfs || fs_cyc != exp_cyc)
      $display("FAIL barker_pulse got %0d pulses at %0d exp %0d at %0d", nfs, fs_cyc, exp_nfs, exp_cyc);
    else n_pass++;
  endtask

  task automatic test_random();
    int t;
    do_reset();
    sched.delete();
    t = 0;
    for (int k = 0; k < 30; k++) begin
      sched.push_back('{t: t, i: 2'($urandom), q: 2'($urandom)});
      t += int'($urandom_range(1, 6));
    end
    run_sched(t + 12);
    for (int c = 1; c <= t + 12; c++) begin
      n_total++;
      if ({obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]} !==
          {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]})
        $display("FAIL random cycle %0d got %b exp %b", c,
                 {obs_out[c], obs_val[c], obs_ovf[c], obs_err[c], obs_fs[c]},
                 {exp_out[c], exp_val[c], exp_ovf[c], exp_err[c], exp_fs[c]});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_sym_err();
    test_reset_mid();
    test_barker();
    for (int r = 0; r < 4; r++) test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
